// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
//   rx_state_e     : controller FSM states
//   rx_cfg_t       : receiver configuration {par_en, par_typ, prescale}
//   CfgRst         : configuration applied out of reset (parity on, even, prescale 8)
//   Prescale8/16/32: the only prescale values the receiver accepts
//   EntryW         : FIFO entry width {data[7:0], par_err, stp_err}
package uart_rx_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
  } rx_cfg_t;

  localparam logic       ParEnRst    = 1'b1;
  localparam logic       ParTypRst   = 1'b0;
  localparam logic [5:0] PrescaleRst = 6'd8;

  localparam rx_cfg_t CfgRst = '{par_en: ParEnRst, par_typ: ParTypRst, prescale: PrescaleRst};

  localparam logic [5:0] Prescale8  = 6'd8;
  localparam logic [5:0] Prescale16 = 6'd16;
  localparam logic [5:0] Prescale32 = 6'd32;

  localparam int unsigned EntryW = 10;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == Prescale8) || (p == Prescale16) || (p == Prescale32);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bus bundle between the UART receive controller and its environment.
//   Config   : cfg_wr, cfg_par_en, cfg_par_typ, cfg_prescale -> cfg_busy, cfg_err
//   Applied  : PAR_EN, PAR_TYP, prescale (towards the receiver)
//   Receiver : RX_IN, rx_data_valid, rx_par_err, rx_stp_err, rx_p_data
//   FIFO     : fifo_valid, fifo_data, fifo_par_err, fifo_stp_err, fifo_rd
//   Status   : ovf, ovf_clr, rx_timeout, rx_active
// slave is the controller side, master is the environment side.
interface uart_rx_ctrl_if;

  logic       cfg_wr;
  logic       cfg_par_en;
  logic       cfg_par_typ;
  logic [5:0] cfg_prescale;
  logic       cfg_busy;
  logic       cfg_err;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       RX_IN;
  logic       rx_data_valid;
  logic       rx_par_err;
  logic       rx_stp_err;
  logic [7:0] rx_p_data;
  logic       fifo_valid;
  logic [7:0] fifo_data;
  logic       fifo_par_err;
  logic       fifo_stp_err;
  logic       fifo_rd;
  logic       ovf;
  logic       ovf_clr;
  logic       rx_timeout;
  logic       rx_active;

  modport slave (
    input  cfg_wr, cfg_par_en, cfg_par_typ, cfg_prescale,
    input  RX_IN, rx_data_valid, rx_par_err, rx_stp_err, rx_p_data,
    input  fifo_rd, ovf_clr,
    output cfg_busy, cfg_err, PAR_EN, PAR_TYP, prescale,
    output fifo_valid, fifo_data, fifo_par_err, fifo_stp_err,
    output ovf, rx_timeout, rx_active
  );

  modport master (
    output cfg_wr, cfg_par_en, cfg_par_typ, cfg_prescale,
    output RX_IN, rx_data_valid, rx_par_err, rx_stp_err, rx_p_data,
    output fifo_rd, ovf_clr,
    input  cfg_busy, cfg_err, PAR_EN, PAR_TYP, prescale,
    input  fifo_valid, fifo_data, fifo_par_err, fifo_stp_err,
    input  ovf, rx_timeout, rx_active
  );

endinterface

// File: rtl/rx_frame_fifo.sv
// Received-frame FIFO with combinational head.
//   clk_i, rst_ni : clock, synchronous active-low reset (pointers only)
//   push_i/data_i : write request and entry
//   pop_i         : read request, ignored when empty
//   full_o/empty_o: status; head_o: oldest entry (valid when !empty_o)
// A push while full only lands if a pop frees a slot on the same edge.
module rx_frame_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [EntryW-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [EntryW-1:0] head_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EntryW-1:0] mem_q [Depth];
  logic              push_en, pop_en;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_i);

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
  assign head_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame tracking FSM, receiver configuration staging and a
// received-frame FIFO with sticky overflow.
//   clk, rst_n : clock, synchronous active-low reset
//   bus_io     : uart_rx_ctrl_if.slave (config, applied config, receiver pulses, FIFO, status)
// Build option: define UART_RX_CTRL_TIMEOUT_EN to enable the frame watchdog, which ends a
// frame after prescale*FRAME_BITS ACTIVE cycles without a frame-end pulse. Without it
// rx_timeout is tied low and only frame-end pulses leave ACTIVE.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_BITS = 12
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_ctrl_if.slave bus_io
);

  rx_state_e         state_q, state_d;
  rx_cfg_t           cfg_q, cfg_d, pend_q, pend_d;
  logic              rx_q;
  logic              busy_q, busy_d;
  logic              cfg_err_q;
  logic              ovf_q, ovf_d;
  logic              fall_edge, frame_end, wd_expire, push, ovf_set, apply, cfg_legal;
  logic              full, empty;
  logic [EntryW-1:0] head;

  assign fall_edge = rx_q & ~bus_io.RX_IN;
  assign frame_end = bus_io.rx_data_valid | bus_io.rx_par_err | bus_io.rx_stp_err;
  assign push      = (state_q == StActive) & frame_end;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic [8:0] wd_cnt_q, wd_cnt_d, wd_limit;

  // Limit is taken from the applied prescale, which is frozen while ACTIVE.
  assign wd_limit  = 9'(32'(cfg_q.prescale) * FRAME_BITS - 32'd1);
  assign wd_expire = (state_q == StActive) & ~frame_end & (wd_cnt_q == wd_limit);

  // Held at zero in IDLE so the first ACTIVE cycle counts as 0.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == StActive) begin
      wd_cnt_d = wd_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_frame_bits;
  assign unused_frame_bits = ^FRAME_BITS;
  assign wd_expire         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (fall_edge) state_d = StActive;
      StActive: if (frame_end || wd_expire) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Staged config lands only in IDLE and never on a start-bit edge, so the receiver
  // never sees a change mid-frame.
  assign cfg_legal = prescale_legal(bus_io.cfg_prescale);
  assign apply     = busy_q & (state_q == StIdle) & ~fall_edge;

  always_comb begin
    cfg_d  = cfg_q;
    pend_d = pend_q;
    busy_d = busy_q;
    if (apply) begin
      cfg_d  = pend_q;
      busy_d = 1'b0;
    end
    // A new write on the apply edge re-arms with the newer value.
    if (bus_io.cfg_wr && cfg_legal) begin
      pend_d.par_en   = bus_io.cfg_par_en;
      pend_d.par_typ  = bus_io.cfg_par_typ;
      pend_d.prescale = bus_io.cfg_prescale;
      busy_d          = 1'b1;
    end
  end

  // A full FIFO only drops the push when nothing is popped on the same edge.
  assign ovf_set = push & full & ~bus_io.fifo_rd;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (bus_io.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rx_q      <= 1'b1;
      cfg_q     <= CfgRst;
      pend_q    <= CfgRst;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_q      <= bus_io.RX_IN;
      cfg_q     <= cfg_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      cfg_err_q <= bus_io.cfg_wr & ~cfg_legal;
      ovf_q     <= ovf_d;
    end
  end

  rx_frame_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  ({bus_io.rx_p_data, bus_io.rx_par_err, bus_io.rx_stp_err}),
    .pop_i   (bus_io.fifo_rd),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign bus_io.cfg_busy     = busy_q;
  assign bus_io.cfg_err      = cfg_err_q;
  assign bus_io.PAR_EN       = cfg_q.par_en;
  assign bus_io.PAR_TYP      = cfg_q.par_typ;
  assign bus_io.prescale     = cfg_q.prescale;
  assign bus_io.fifo_valid   = ~empty;
  assign bus_io.fifo_data    = head[9:2];
  assign bus_io.fifo_par_err = head[1];
  assign bus_io.fifo_stp_err = head[0];
  assign bus_io.ovf          = ovf_q;
  assign bus_io.rx_timeout   = wd_expire;
  assign bus_io.rx_active    = (state_q == StActive);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames and config writes, a queue-based reference
// model compared on every falling clock edge, plus hand-computed literal checks.
module tb_uart_rx_ctrl;

  localparam int unsigned Depth     = 4;
  localparam int unsigned FrameBits = 12;

  logic clk = 1'b0;
  logic rst_n;

  uart_rx_ctrl_if rx_if ();

  uart_rx_ctrl #(
    .FIFO_DEPTH (Depth),
    .FRAME_BITS (FrameBits)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (rx_if)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] m_fifo [$];
  bit         m_valid = 1'b0;
  bit         m_active, m_rxq, m_ovf, m_busy, m_err;
  int         m_cnt;
  bit         m_par_en, m_par_typ, m_pend_en, m_pend_typ;
  logic [5:0] m_presc, m_pend_presc;

  function automatic bit legal(input logic [5:0] p);
    return (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
  endfunction

  function automatic bit any_frame_end();
    return (rx_if.rx_data_valid | rx_if.rx_par_err | rx_if.rx_stp_err) == 1'b1;
  endfunction

  // Frame abandoned after prescale*FrameBits ACTIVE cycles without a frame-end.
  function automatic bit model_timeout();
`ifdef UART_RX_CTRL_TIMEOUT_EN
    return m_active && !any_frame_end() && (m_cnt == int'(m_presc) * int'(FrameBits) - 1);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin : model
    bit fe, fall, tmo, push, pop, drop, apply;
    if (m_valid) begin
      check("rx_active", 32'(rx_if.rx_active), 32'(m_active));
      check("fifo_valid", 32'(rx_if.fifo_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0)
        check("fifo_head", 32'({rx_if.fifo_data, rx_if.fifo_par_err, rx_if.fifo_stp_err}),
              32'(m_fifo[0]));
      check("ovf", 32'(rx_if.ovf), 32'(m_ovf));
      check("cfg_busy", 32'(rx_if.cfg_busy), 32'(m_busy));
      check("cfg_err", 32'(rx_if.cfg_err), 32'(m_err));
      check("applied_cfg", 32'({rx_if.PAR_EN, rx_if.PAR_TYP, rx_if.prescale}),
            32'({m_par_en, m_par_typ, m_presc}));
      check("rx_timeout", 32'(rx_if.rx_timeout), 32'(model_timeout()));
    end
    if (!rst_n) begin
      m_fifo.delete();
      m_active = 0; m_rxq = 1; m_ovf = 0; m_busy = 0; m_err = 0; m_cnt = 0;
      m_par_en = 1; m_par_typ = 0; m_presc = 6'd8;
      m_pend_en = 1; m_pend_typ = 0; m_pend_presc = 6'd8;
      m_valid = 1'b1;
    end else if (m_valid) begin
      fe    = any_frame_end();
      fall  = m_rxq && !rx_if.RX_IN;
      tmo   = model_timeout();
      push  = m_active && fe;
      pop   = rx_if.fifo_rd && (m_fifo.size() != 0);
      drop  = push && (m_fifo.size() == Depth) && !rx_if.fifo_rd;
      if (pop) void'(m_fifo.pop_front());
      if (push && !drop) m_fifo.push_back({rx_if.rx_p_data, rx_if.rx_par_err, rx_if.rx_stp_err});
      if (drop) m_ovf = 1;
      else if (rx_if.ovf_clr) m_ovf = 0;
      apply = !m_active && m_busy && !fall;
      m_err = rx_if.cfg_wr && !legal(rx_if.cfg_prescale);
      if (apply) begin
        m_par_en = m_pend_en; m_par_typ = m_pend_typ; m_presc = m_pend_presc; m_busy = 0;
      end
      if (rx_if.cfg_wr && legal(rx_if.cfg_prescale)) begin
        m_pend_en = rx_if.cfg_par_en; m_pend_typ = rx_if.cfg_par_typ;
        m_pend_presc = rx_if.cfg_prescale; m_busy = 1;
      end
      if (!m_active) begin
        if (fall) begin m_active = 1; m_cnt = 0; end
      end else if (push || tmo) m_active = 0;
      else m_cnt++;
      m_rxq = rx_if.RX_IN;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_if.cfg_wr = 0; rx_if.cfg_par_en = 0; rx_if.cfg_par_typ = 0; rx_if.cfg_prescale = 6'd0;
    rx_if.RX_IN = 1; rx_if.rx_data_valid = 0; rx_if.rx_par_err = 0; rx_if.rx_stp_err = 0;
    rx_if.rx_p_data = 8'h00; rx_if.fifo_rd = 0; rx_if.ovf_clr = 0;
  endtask

  task automatic start_frame();
    rx_if.RX_IN = 0;
    tick();
    rx_if.RX_IN = 1;
  endtask

  task automatic end_frame(input logic [7:0] d, input bit dv, input bit pe, input bit se,
                           input bit rd);
    rx_if.rx_p_data = d; rx_if.rx_data_valid = dv; rx_if.rx_par_err = pe;
    rx_if.rx_stp_err = se; rx_if.fifo_rd = rd;
    tick();
    rx_if.rx_data_valid = 0; rx_if.rx_par_err = 0; rx_if.rx_stp_err = 0; rx_if.fifo_rd = 0;
  endtask

  task automatic frame(input logic [7:0] d, input bit dv, input bit pe, input bit se,
                       input int gap);
    start_frame();
    repeat (gap) tick();
    end_frame(d, dv, pe, se, 1'b0);
  endtask

  task automatic pop();
    rx_if.fifo_rd = 1;
    tick();
    rx_if.fifo_rd = 0;
  endtask

  task automatic cfg_write(input logic [5:0] p, input bit en, input bit typ);
    rx_if.cfg_wr = 1; rx_if.cfg_prescale = p; rx_if.cfg_par_en = en; rx_if.cfg_par_typ = typ;
    tick();
    rx_if.cfg_wr = 0;
  endtask

  initial begin : stim
    logic [7:0] drain_exp [4];
    int         seen;
    drain_exp = '{8'h22, 8'h33, 8'h44, 8'h66};
    idle_inputs();
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;

    // Reset state
    check("rst_active", 32'(rx_if.rx_active), 32'd0);
    check("rst_fifo_valid", 32'(rx_if.fifo_valid), 32'd0);
    check("rst_cfg", 32'({rx_if.PAR_EN, rx_if.PAR_TYP, rx_if.prescale}), 32'({2'b10, 6'd8}));
    check("rst_busy_ovf", 32'({rx_if.cfg_busy, rx_if.ovf, rx_if.cfg_err}), 32'd0);

    // Single frame 0xA5
    frame(8'hA5, 1, 0, 0, 5);
    check("a5_valid", 32'(rx_if.fifo_valid), 32'd1);
    check("a5_data", 32'(rx_if.fifo_data), 32'hA5);
    check("a5_flags", 32'({rx_if.fifo_par_err, rx_if.fifo_stp_err}), 32'd0);
    check("a5_active", 32'(rx_if.rx_active), 32'd0);
    pop();
    check("a5_popped", 32'(rx_if.fifo_valid), 32'd0);

    // Config written mid-frame applies after the frame
    start_frame();
    repeat (3) tick();
    cfg_write(6'd16, 0, 1);
    check("mid_busy", 32'(rx_if.cfg_busy), 32'd1);
    repeat (4) tick();
    check("mid_presc_held", 32'(rx_if.prescale), 32'd8);
    end_frame(8'h3C, 1, 0, 0, 0);
    check("mid_presc_frame_end", 32'(rx_if.prescale), 32'd8);
    tick();
    check("mid_cfg_applied", 32'({rx_if.PAR_EN, rx_if.PAR_TYP, rx_if.prescale}),
          32'({2'b01, 6'd16}));
    check("mid_busy_clr", 32'(rx_if.cfg_busy), 32'd0);
    pop();

    // Illegal prescale
    cfg_write(6'd12, 1, 0);
    check("bad_err", 32'(rx_if.cfg_err), 32'd1);
    check("bad_busy", 32'(rx_if.cfg_busy), 32'd0);
    check("bad_presc", 32'(rx_if.prescale), 32'd16);
    tick();
    check("bad_err_pulse", 32'(rx_if.cfg_err), 32'd0);

    // Start bit on the apply cycle defers the apply until the frame ends
    cfg_write(6'd8, 1, 0);
    start_frame();
    check("defer_active", 32'(rx_if.rx_active), 32'd1);
    check("defer_presc", 32'(rx_if.prescale), 32'd16);
    repeat (3) tick();
    end_frame(8'h81, 0, 0, 1, 0);
    check("defer_head", 32'({rx_if.fifo_data, rx_if.fifo_par_err, rx_if.fifo_stp_err}),
          32'({8'h81, 2'b01}));
    pop();
    check("defer_applied", 32'({rx_if.PAR_EN, rx_if.PAR_TYP, rx_if.prescale}),
          32'({2'b10, 6'd8}));

    // Back-to-back writes mid-frame: the last one wins
    start_frame();
    cfg_write(6'd32, 0, 0);
    cfg_write(6'd8, 1, 1);
    end_frame(8'h00, 1, 0, 0, 0);
    tick();
    check("last_wins", 32'({rx_if.PAR_EN, rx_if.PAR_TYP, rx_if.prescale}), 32'({2'b11, 6'd8}));
    pop();

    // Overflow: five frames into a four-deep FIFO
    frame(8'h11, 1, 0, 0, 2);
    frame(8'h22, 0, 1, 0, 2);
    frame(8'h33, 0, 0, 1, 2);
    frame(8'h44, 1, 0, 0, 2);
    check("ovf_before", 32'(rx_if.ovf), 32'd0);
    frame(8'h55, 1, 0, 0, 2);
    check("ovf_set", 32'(rx_if.ovf), 32'd1);
    check("ovf_head", 32'(rx_if.fifo_data), 32'h11);
    rx_if.ovf_clr = 1; tick(); rx_if.ovf_clr = 0;
    check("ovf_clr", 32'(rx_if.ovf), 32'd0);
    start_frame();
    end_frame(8'h66, 1, 0, 0, 1);
    check("full_push_pop_ovf", 32'(rx_if.ovf), 32'd0);
    check("full_push_pop_head", 32'({rx_if.fifo_data, rx_if.fifo_par_err}), 32'({8'h22, 1'b1}));
    start_frame();
    rx_if.ovf_clr = 1;
    end_frame(8'h77, 1, 0, 0, 0);
    rx_if.ovf_clr = 0;
    check("ovf_set_wins", 32'(rx_if.ovf), 32'd1);
    rx_if.ovf_clr = 1; tick(); rx_if.ovf_clr = 0;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(rx_if.fifo_data), 32'(drain_exp[i]));
      pop();
    end
    check("drained", 32'(rx_if.fifo_valid), 32'd0);
    pop();
    check("pop_empty", 32'(rx_if.fifo_valid), 32'd0);

    // Watchdog
    start_frame();
    seen = 0;
    for (int k = 1; k <= 200; k++) begin
      if (rx_if.rx_timeout === 1'b1) begin
        seen = k;
        break;
      end
      tick();
    end
`ifdef UART_RX_CTRL_TIMEOUT_EN
    check("wd_cycle", 32'(seen), 32'd96);
    tick();
    check("wd_idle", 32'(rx_if.rx_active), 32'd0);
    check("wd_no_push", 32'(rx_if.fifo_valid), 32'd0);
`else
    check("wd_none", 32'(seen), 32'd0);
    check("wd_still_active", 32'(rx_if.rx_active), 32'd1);
    end_frame(8'h5A, 1, 0, 0, 0);
    check("wd_frame_pushed", 32'(rx_if.fifo_data), 32'h5A);
    pop();
`endif

    // Reset mid-frame with two entries and a pending config
    frame(8'hAA, 1, 0, 0, 2);
    frame(8'hBB, 1, 0, 0, 2);
    start_frame();
    cfg_write(6'd32, 0, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("rst2_fifo", 32'(rx_if.fifo_valid), 32'd0);
    check("rst2_active", 32'(rx_if.rx_active), 32'd0);
    check("rst2_cfg", 32'({rx_if.PAR_EN, rx_if.PAR_TYP, rx_if.prescale}), 32'({2'b10, 6'd8}));
    check("rst2_busy", 32'(rx_if.cfg_busy), 32'd0);
    repeat (3) tick();
    check("rst2_pend_dropped", 32'(rx_if.prescale), 32'd8);
    frame(8'hC3, 1, 0, 0, 4);
    check("post_rst_frame", 32'(rx_if.fifo_data), 32'hC3);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of received-frame entries (power of two, 2..16).
REQ-002 SHALL have parameter FRAME_BITS, default 12, meaning watchdog length in bit periods.
REQ-003 SHALL have clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have cfg_wr  in  1  config write strobe; cfg_par_en in 1, cfg_par_typ in 1, cfg_prescale in 6: requested config.
REQ-006 SHALL have cfg_busy  out  1  config write pending; cfg_err  out  1  one-cycle pulse, illegal prescale rejected.
REQ-007 SHALL have PAR_EN  out  1, PAR_TYP  out  1, prescale  out  6: applied config driven to the receiver.
REQ-008 SHALL have RX_IN  in  1  serial line (monitor only); rx_data_valid, rx_par_err, rx_stp_err  in  1  receiver frame-end pulses; rx_p_data  in  8  receiver data.
REQ-009 SHALL have fifo_valid  out  1, fifo_data  out  8, fifo_par_err  out  1, fifo_stp_err  out  1: FIFO head; fifo_rd  in  1  pop.
REQ-010 SHALL have ovf  out  1  sticky overflow; ovf_clr  in  1; rx_timeout  out  1  one-cycle watchdog pulse; rx_active  out  1  frame in progress.

Function
REQ-011 SHALL implement states IDLE and ACTIVE; rx_active=1 exactly in ACTIVE.
REQ-012 SHALL register RX_IN each cycle (rx_q); falling edge = rx_q=1 and RX_IN=0.
REQ-013 IDLE->ACTIVE on falling edge; ACTIVE->IDLE on first of rx_data_valid, rx_par_err, rx_stp_err, or watchdog expiry.
REQ-014 SHALL, on the ACTIVE cycle with any frame-end pulse, push one entry {rx_p_data, rx_par_err, rx_stp_err}; further pulses in IDLE ignored.
REQ-015 Watchdog: 9-bit counter cleared on IDLE->ACTIVE, increments in ACTIVE; at count = prescale*FRAME_BITS-1 without frame-end: ->IDLE, rx_timeout=1 one cycle, no push.
REQ-016 Legal prescale = 8, 16, 32; cfg_wr with other value: cfg_err pulse next cycle, pending/applied config unchanged.
REQ-017 Legal cfg_wr SHALL load pending register, cfg_busy=1 next cycle; cfg_wr while pending overwrites (last wins).
REQ-018 Pending config SHALL apply on a cycle in IDLE with no falling edge; outputs update next cycle, cfg_busy clears same edge.
REQ-019 Falling edge in the apply cycle SHALL defer apply until next IDLE; config never changes while ACTIVE.
REQ-020 FIFO: fifo_valid = not empty, head combinational from storage; fifo_rd when empty ignored.
REQ-021 Push when full without pop: entry dropped, ovf=1; push+pop when full: both occur, no overflow.
REQ-022 ovf clears on ovf_clr unless overflow in same cycle (set wins).
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH with extra bit for full/empty.

Reset
REQ-024 rst_n=0: state IDLE, FIFO empty, pointers 0, ovf=0, cfg_busy=0, cfg_err=0, rx_timeout=0, rx_q=1, watchdog 0.
REQ-025 Reset values: PAR_EN=1, PAR_TYP=0, prescale=8; pending config discarded; reset mid-frame abandons frame without push.

Configuration
REQ-026 Macro UART_RX_CTRL_TIMEOUT_EN defined: watchdog per REQ-015.
REQ-027 Macro undefined: no watchdog counter, rx_timeout tied 0, ACTIVE exits only on frame-end pulses.

Structure
REQ-028 Shared package uart_rx_pkg SHALL hold state enum, reset config constants (8, 1, 0), legal prescale constants, FIFO entry width (10).
REQ-029 FIFO SHALL be sub-module rx_frame_fifo (push, pop, full, empty, head); controller FSM and config logic stay in uart_rx_ctrl.

Verification
REQ-030 Frame 0xA5 (prescale 8), rx_data_valid pulse -> fifo_valid=1, fifo_data=0xA5, flags 0, rx_active low next cycle.
REQ-031 cfg_wr prescale=16 mid-frame -> cfg_busy=1, prescale stays 8 until frame end, then 16, cfg_busy=0.
REQ-032 cfg_wr prescale=12 -> cfg_err pulse, prescale unchanged, cfg_busy=0.
REQ-033 5 frames, no pops, depth 4 -> 4 entries kept, ovf=1; push+pop when full -> ovf unchanged.
REQ-034 Macro on, falling edge, no frame-end, prescale 8 -> rx_timeout at ACTIVE cycle 96, no push.
REQ-035 rst_n=0 mid-frame with 2 entries -> FIFO empty, IDLE, PAR_EN=1, PAR_TYP=0, prescale=8.
